// File: rtl/frame_counter_pkg.sv
// Shared definitions for the frame counter: register offsets, CTRL bit
// positions, AXI response codes and the AXI channel state encodings.
package frame_counter_pkg;

    localparam logic [31:0] ADDR_CTRL      = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS    = 32'h0000_0004;
    localparam logic [31:0] ADDR_INFO      = 32'h0000_0008;
    localparam logic [31:0] ADDR_COMPARE   = 32'h0000_000C;
    localparam logic [31:0] ADDR_SNAP_BASE = 32'h0000_0040;
    localparam logic [31:0] ADDR_LIVE_BASE = 32'h0000_0080;

    localparam int unsigned CTRL_ENABLE   = 0;
    localparam int unsigned CTRL_SNAPSHOT = 1;
    localparam int unsigned CTRL_CLEAR    = 2;
    localparam int unsigned CTRL_IRQ_EN   = 3;

    localparam int unsigned STATUS_MATCH_LSB = 16;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ACCEPT,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ACCEPT,
        R_DATA
    } rd_state_t;

    // Registers are word-aligned; the two byte-lane bits never select a register.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/frame_counter_ch.sv
// One frame counter channel: rising-edge detect, wrapping counter, sticky
// overflow flag, snapshot register and (with FCNT_IRQ_EN) a sticky compare
// match flag.
module frame_counter_ch
    import frame_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_frame_pulse,
    input  logic                 i_enable,
    input  logic                 i_clear,
    input  logic                 i_snapshot,
    input  logic                 i_ovf_clr,
    input  logic                 i_match_clr,
    input  logic [31:0]          i_compare,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic [CNT_WIDTH-1:0] o_snap,
    output logic                 o_ovf,
    output logic                 o_match
);

    logic                 r_prev;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_snap;
    logic                 r_ovf;
    logic                 w_edge;
    logic                 w_inc;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    assign w_edge     = i_frame_pulse & ~r_prev;
    // clear_all takes priority over a coincident edge
    assign w_inc      = i_enable & w_edge & ~i_clear;
    assign w_cnt_next = r_cnt + CNT_WIDTH'(1);

    // Previous pulse level; tracks the input even while counting is disabled
    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= i_frame_pulse;
    end

    // Frame counter: clear, else increment (wrapping) on a counted edge
    always_ff @(posedge i_clk) begin
        if (i_rst)        r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (w_inc)   r_cnt <= w_cnt_next;
    end

    // Snapshot captures the count from before this cycle's edge or clear
    always_ff @(posedge i_clk) begin
        if (i_rst)           r_snap <= '0;
        else if (i_snapshot) r_snap <= r_cnt;
    end

    // Sticky overflow on wrap; a new wrap beats a simultaneous W1C
    always_ff @(posedge i_clk) begin
        if (i_rst)                  r_ovf <= 1'b0;
        else if (w_inc && (&r_cnt)) r_ovf <= 1'b1;
        else if (i_ovf_clr)         r_ovf <= 1'b0;
    end

`ifdef FCNT_IRQ_EN
    logic r_match;

    // Sticky compare match when an increment lands on COMPARE; set beats W1C
    always_ff @(posedge i_clk) begin
        if (i_rst)                                       r_match <= 1'b0;
        else if (w_inc && (32'(w_cnt_next) == i_compare)) r_match <= 1'b1;
        else if (i_match_clr)                            r_match <= 1'b0;
    end

    assign o_match = r_match;
`else
    logic w_unused_ch;
    assign w_unused_ch = ^{i_compare, i_match_clr};
    assign o_match     = 1'b0;
`endif

    assign o_cnt  = r_cnt;
    assign o_snap = r_snap;
    assign o_ovf  = r_ovf;

endmodule

// File: rtl/frame_counter_axil.sv
// Multi-channel frame counter with an AXI4-Lite register slave.
// Optional feature macro: FCNT_IRQ_EN (COMPARE register, match flags, irq port).
module frame_counter_axil
    import frame_counter_pkg::*;
#(
    parameter int unsigned NUM_CH               = 4,
    parameter int unsigned CNT_WIDTH            = 32,
    parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S00_AXI_ADDR_WIDTH = 8
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [NUM_CH-1:0]                 frame_pulse,
`ifdef FCNT_IRQ_EN
    output logic                              irq,
`endif
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    wr_state_t r_wr_state, w_wr_state_next;
    rd_state_t r_rd_state, w_rd_state_next;

    logic                 r_enable;
    logic                 r_irq_en;
    logic [31:0]          r_rdata;
    logic [31:0]          w_rdata;
    logic [31:0]          w_waddr;
    logic [31:0]          w_raddr;
    logic [31:0]          w_compare;
    logic                 w_wr_en;
    logic                 w_wr_ctrl;
    logic                 w_wr_status;
    logic                 w_wr_compare;
    logic                 w_snapshot;
    logic                 w_clear_all;
    logic [NUM_CH-1:0]    w_ovf_clr;
    logic [NUM_CH-1:0]    w_match_clr;
    logic [NUM_CH-1:0]    w_ovf;
    logic [NUM_CH-1:0]    w_match;
    logic [CNT_WIDTH-1:0] w_live [NUM_CH];
    logic [CNT_WIDTH-1:0] w_snap [NUM_CH];
    logic                 w_unused_bits;

    // ---------------- write channel ----------------
    // Write FSM state register
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) r_wr_state <= W_IDLE;
        else                r_wr_state <= w_wr_state_next;
    end

    // Write FSM: wait for AW and W together, accept for one cycle, then respond
    always_comb begin
        w_wr_state_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:   if (s00_axi_awvalid && s00_axi_wvalid) w_wr_state_next = W_ACCEPT;
            W_ACCEPT: w_wr_state_next = W_RESP;
            W_RESP:   if (s00_axi_bready) w_wr_state_next = W_IDLE;
            default:  w_wr_state_next = W_IDLE;
        endcase
    end

    // Write channel handshake outputs decoded from the registered state
    always_comb begin
        s00_axi_awready = 1'b0;
        s00_axi_wready  = 1'b0;
        s00_axi_bvalid  = 1'b0;
        case (r_wr_state)
            W_ACCEPT: begin
                s00_axi_awready = 1'b1;
                s00_axi_wready  = 1'b1;
            end
            W_RESP:   s00_axi_bvalid = 1'b1;
            default:  ;
        endcase
    end

    assign s00_axi_bresp = RESP_OKAY;

    // The register write lands on the same edge that completes the AW/W handshake
    assign w_wr_en      = (r_wr_state == W_ACCEPT);
    assign w_waddr      = word_addr(32'(s00_axi_awaddr));
    assign w_wr_ctrl    = w_wr_en && (w_waddr == ADDR_CTRL);
    assign w_wr_status  = w_wr_en && (w_waddr == ADDR_STATUS);
    assign w_wr_compare = w_wr_en && (w_waddr == ADDR_COMPARE);
    assign w_snapshot   = w_wr_ctrl && s00_axi_wstrb[0] && s00_axi_wdata[CTRL_SNAPSHOT];
    assign w_clear_all  = w_wr_ctrl && s00_axi_wstrb[0] && s00_axi_wdata[CTRL_CLEAR];
    assign w_ovf_clr    = w_wr_status ? s00_axi_wdata[NUM_CH-1:0] : '0;
    assign w_match_clr  = w_wr_status ? s00_axi_wdata[STATUS_MATCH_LSB +: NUM_CH] : '0;

    // CTRL persistent bits, gated by the low byte strobe
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
        end else if (w_wr_ctrl && s00_axi_wstrb[0]) begin
            r_enable <= s00_axi_wdata[CTRL_ENABLE];
            r_irq_en <= s00_axi_wdata[CTRL_IRQ_EN];
        end
    end

`ifdef FCNT_IRQ_EN
    logic [31:0] r_compare;
    logic        r_irq;

    // COMPARE register with per-byte strobes
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_compare <= '0;
        end else if (w_wr_compare) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (s00_axi_wstrb[b]) r_compare[8*b +: 8] <= s00_axi_wdata[8*b +: 8];
            end
        end
    end

    // Level interrupt, registered from the sticky match flags
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) r_irq <= 1'b0;
        else                r_irq <= r_irq_en & (|w_match);
    end

    assign w_compare = r_compare;
    assign irq       = r_irq;
`else
    assign w_compare = '0;
`endif

    assign w_unused_bits = ^{s00_axi_wdata, s00_axi_wstrb, w_match, w_wr_compare};

    // ---------------- channels ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        frame_counter_ch #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .i_clk        (s00_axi_aclk),
            .i_rst        (s00_axi_areset),
            .i_frame_pulse(frame_pulse[g]),
            .i_enable     (r_enable),
            .i_clear      (w_clear_all),
            .i_snapshot   (w_snapshot),
            .i_ovf_clr    (w_ovf_clr[g]),
            .i_match_clr  (w_match_clr[g]),
            .i_compare    (w_compare),
            .o_cnt        (w_live[g]),
            .o_snap       (w_snap[g]),
            .o_ovf        (w_ovf[g]),
            .o_match      (w_match[g])
        );
    end

    // ---------------- read channel ----------------
    // Read FSM state register
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) r_rd_state <= R_IDLE;
        else                r_rd_state <= w_rd_state_next;
    end

    // Read FSM: accept AR for one cycle, then hold data until RREADY
    always_comb begin
        w_rd_state_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:   if (s00_axi_arvalid) w_rd_state_next = R_ACCEPT;
            R_ACCEPT: w_rd_state_next = R_DATA;
            R_DATA:   if (s00_axi_rready) w_rd_state_next = R_IDLE;
            default:  w_rd_state_next = R_IDLE;
        endcase
    end

    // Read channel handshake outputs decoded from the registered state
    always_comb begin
        s00_axi_arready = (r_rd_state == R_ACCEPT);
        s00_axi_rvalid  = (r_rd_state == R_DATA);
    end

    // Read address decode; unmapped offsets return zero
    always_comb begin
        w_raddr = word_addr(32'(s00_axi_araddr));
        w_rdata = '0;
        if (w_raddr == ADDR_CTRL) begin
            w_rdata[CTRL_ENABLE] = r_enable;
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
        end
        if (w_raddr == ADDR_STATUS) begin
            w_rdata[NUM_CH-1:0] = w_ovf;
`ifdef FCNT_IRQ_EN
            w_rdata[STATUS_MATCH_LSB +: NUM_CH] = w_match;
`endif
        end
        if (w_raddr == ADDR_INFO) w_rdata = {16'h0000, 8'(CNT_WIDTH), 8'(NUM_CH)};
`ifdef FCNT_IRQ_EN
        if (w_raddr == ADDR_COMPARE) w_rdata = r_compare;
`endif
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_raddr == ADDR_SNAP_BASE + 4 * i) w_rdata = 32'(w_snap[i]);
            if (w_raddr == ADDR_LIVE_BASE + 4 * i) w_rdata = 32'(w_live[i]);
        end
    end

    // Read data register, loaded on the AR handshake and held while RVALID
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset)              r_rdata <= '0;
        else if (r_rd_state == R_ACCEPT) r_rdata <= w_rdata;
    end

    assign s00_axi_rdata = r_rdata;
    assign s00_axi_rresp = RESP_OKAY;

endmodule

// File: tb/tb_frame_counter_axil.sv
// Self-checking bench for frame_counter_axil (NUM_CH=4, CNT_WIDTH=8) against a
// behavioural model of the register map. Define FCNT_IRQ_EN for the irq build.
module tb_frame_counter_axil;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned MODV = 1 << CW;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] frame_pulse;
    logic [7:0]     awaddr, araddr;
    logic           awvalid, awready, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rvalid, rready;
    logic [31:0]    wdata, rdata;
    logic [3:0]     wstrb;
    logic [1:0]     bresp, rresp;
`ifdef FCNT_IRQ_EN
    logic           irq;
`endif

    frame_counter_axil #(
        .NUM_CH(NCH), .CNT_WIDTH(CW), .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(8)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst), .frame_pulse(frame_pulse),
`ifdef FCNT_IRQ_EN
        .irq(irq),
`endif
        .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready), .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned    m_cnt  [NCH];
    int unsigned    m_snap [NCH];
    logic [NCH-1:0] m_prev, m_ovf, m_match;
    bit             m_en, m_irq_en;
    logic [31:0]    m_cmp;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        m_prev = '0; m_ovf = '0; m_match = '0;
        m_en = 0; m_irq_en = 0; m_cmp = '0;
    endfunction

    // One clock edge worth of frame strobes seen by the counters
    function automatic void model_edges(input logic [NCH-1:0] fp, input bit clr,
                                        output logic [NCH-1:0] ovf_set,
                                        output logic [NCH-1:0] match_set);
        ovf_set = '0;
        match_set = '0;
        for (int i = 0; i < NCH; i++) begin
            if (fp[i] && !m_prev[i] && m_en && !clr) begin
                m_cnt[i] = (m_cnt[i] + 1) % MODV;
                if (m_cnt[i] == 0) ovf_set[i] = 1'b1;
`ifdef FCNT_IRQ_EN
                if (m_cnt[i] == m_cmp) match_set[i] = 1'b1;
`endif
            end
        end
        m_prev = fp;
    endfunction

    function automatic void model_step(input logic [NCH-1:0] fp);
        logic [NCH-1:0] os, ms;
        model_edges(fp, 1'b0, os, ms);
        m_ovf   |= os;
        m_match |= ms;
    endfunction

    // A register write together with whatever strobes are present on that edge
    function automatic void model_accept(input logic [7:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb, input logic [NCH-1:0] fp);
        logic [31:0]    a;
        bit             snap, clr;
        logic [NCH-1:0] os, ms;
        a    = 32'(addr) & ~32'h3;
        snap = (a == 0) && strb[0] && data[1];
        clr  = (a == 0) && strb[0] && data[2];
        if (snap) for (int i = 0; i < NCH; i++) m_snap[i] = m_cnt[i];
        model_edges(fp, clr, os, ms);
        if (clr) for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        if (a == 4) begin
            m_ovf &= ~data[NCH-1:0];
`ifdef FCNT_IRQ_EN
            m_match &= ~data[16 +: NCH];
`endif
        end
        m_ovf   |= os;
        m_match |= ms;
        if (a == 0 && strb[0]) begin
            m_en     = data[0];
            m_irq_en = data[3];
        end
`ifdef FCNT_IRQ_EN
        if (a == 12) for (int b = 0; b < 4; b++) if (strb[b]) m_cmp[8*b +: 8] = data[8*b +: 8];
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        logic [31:0] a, r;
        a = 32'(addr) & ~32'h3;
        r = '0;
        if (a == 0) begin
            r[0] = m_en;
            r[3] = m_irq_en;
        end else if (a == 4) begin
            r[NCH-1:0] = m_ovf;
`ifdef FCNT_IRQ_EN
            r[16 +: NCH] = m_match;
`endif
        end else if (a == 8) begin
            r = (CW << 8) | NCH;
`ifdef FCNT_IRQ_EN
        end else if (a == 12) begin
            r = m_cmp;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (a == 32'h40 + 4 * i) r = m_snap[i];
                if (a == 32'h80 + 4 * i) r = m_cnt[i];
            end
        end
        return r;
    endfunction

    // ---------------- bus tasks (entered and left just after a falling edge) ----------------
    task automatic drive_pulse(input logic [NCH-1:0] fp);
        frame_pulse = fp;
        model_step(fp);
        @(negedge clk);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb = 4'hF, input logic [NCH-1:0] acc_pulse = '0,
                             input int aw_lead = 0, input int b_hold = 0);
        logic [NCH-1:0] orig;
        orig    = frame_pulse;
        awaddr  = addr;
        awvalid = 1'b1;
        for (int k = 0; k < aw_lead; k++) begin
            @(negedge clk);
            check_val("aw_before_w", 32'(awready), 0);
        end
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int n = 0; n < 16 && !awready; n++) @(negedge clk);
        check_val("awready", 32'(awready), 1);
        check_val("wready", 32'(wready), 1);
        frame_pulse = orig | acc_pulse;
        model_accept(addr, data, strb, orig | acc_pulse);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        frame_pulse = orig;
        model_step(orig);
        check_val("bvalid", 32'(bvalid), 1);
        check_val("bresp", 32'(bresp), 0);
        for (int k = 0; k < b_hold; k++) begin
            @(negedge clk);
            check_val("bvalid_hold", 32'(bvalid), 1);
            check_val("aw_single", 32'(awready), 0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_val("bvalid_drop", 32'(bvalid), 0);
    endtask

    task automatic axi_read(input logic [7:0] addr, input string tag, input int r_hold = 0);
        logic [31:0] exp;
        exp     = model_read(addr);
        araddr  = addr;
        arvalid = 1'b1;
        for (int n = 0; n < 16 && !arready; n++) @(negedge clk);
        check_val("arready", 32'(arready), 1);
        @(negedge clk);
        arvalid = 1'b0;
        for (int n = 0; n < 16 && !rvalid; n++) @(negedge clk);
        check_val(tag, rdata, exp);
        check_val("rresp", 32'(rresp), 0);
        for (int k = 0; k < r_hold; k++) begin
            @(negedge clk);
            check_val("rvalid_hold", 32'(rvalid), 1);
            check_val("rdata_hold", rdata, exp);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check_val("rvalid_drop", 32'(rvalid), 0);
    endtask

    task automatic read_all(input string tag);
        logic [7:0] addrs [15];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'h48, 8'h4C,
                  8'h80, 8'h84, 8'h88, 8'h8C, 8'h3C, 8'hFC, 8'h10};
        foreach (addrs[k]) axi_read(addrs[k], $sformatf("%s_rd%02h", tag, addrs[k]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        frame_pulse = '0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_awready", 32'(awready), 0);
        check_val("rst_arready", 32'(arready), 0);
        check_val("rst_bvalid", 32'(bvalid), 0);
        check_val("rst_rvalid", 32'(rvalid), 0);
`ifdef FCNT_IRQ_EN
        check_val("rst_irq", 32'(irq), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        read_all("reset");

        // directed counting and a held pulse
        axi_write(8'h00, 32'h1);
        for (int k = 0; k < 5; k++) begin
            drive_pulse((k < 3) ? 4'b0101 : 4'b0001);
            drive_pulse(4'b0000);
        end
        axi_read(8'h80, "live0_5");
        axi_read(8'h84, "live1_0");
        axi_read(8'h88, "live2_3");
        repeat (10) drive_pulse(4'b0001);
        drive_pulse(4'b0000);
        axi_read(8'h80, "live0_held");

        // wrap on ch1, W1C, then W1C colliding with a wrap
        repeat (256) begin drive_pulse(4'b0010); drive_pulse(4'b0000); end
        axi_read(8'h84, "live1_wrap");
        axi_read(8'h04, "status_ovf");
        axi_write(8'h04, 32'h2);
        axi_read(8'h04, "status_w1c");
        repeat (255) begin drive_pulse(4'b0010); drive_pulse(4'b0000); end
        axi_write(8'h04, 32'h2, 4'hF, 4'b0010);
        axi_read(8'h04, "status_set_wins");
        axi_read(8'h84, "live1_wrap2");

        // snapshot coherency and snapshot+clear
        axi_write(8'h00, 32'h5);
        repeat (7) begin drive_pulse(4'b0001); drive_pulse(4'b0000); end
        repeat (3) begin drive_pulse(4'b1110); drive_pulse(4'b0000); end
        axi_write(8'h00, 32'h3, 4'hF, 4'b0001);
        axi_read(8'h40, "snap0_pre_edge");
        axi_read(8'h80, "live0_post_edge");
        axi_write(8'h00, 32'h7);
        read_all("snapclr");

        // AXI handshake corners, strobes, unmapped writes, freeze on disable
        axi_write(8'h0C, 32'h0000_00A5, 4'hF, '0, 3, 4);
        axi_read(8'h0C, "compare_hold", 5);
        axi_write(8'h3C, 32'hFFFF_FFFF);
        axi_write(8'h00, 32'h0, 4'h0);
        drive_pulse(4'b1111);
        drive_pulse(4'b0000);
        axi_write(8'h00, 32'h0);
        drive_pulse(4'b1111);
        axi_write(8'h00, 32'h1);
        drive_pulse(4'b0000);
        read_all("freeze");

        // randomized traffic
        for (int r = 0; r < 10; r++) begin
            axi_write(8'h00, {28'h0, 1'($urandom), 2'b00, 1'($urandom_range(0, 4) != 0)});
            repeat ($urandom_range(20, 60)) drive_pulse(NCH'($urandom));
            case ($urandom_range(0, 2))
                0: axi_write(8'h00, ($urandom & 32'hF) | 32'h2, 4'hF, NCH'($urandom));
                1: axi_write(8'h04, $urandom, 4'hF, NCH'($urandom));
                default: axi_write(8'h0C, 32'($urandom_range(0, 20)), 4'(($urandom & 4'hF) | 4'h1));
            endcase
            read_all($sformatf("rand%0d", r));
        end

`ifdef FCNT_IRQ_EN
        // compare match and interrupt on ch3
        drive_pulse(4'b0000);
        axi_write(8'h04, 32'hFFFF_FFFF);
        axi_write(8'h0C, 32'h4);
        axi_write(8'h00, 32'hD);
        for (int k = 0; k < 4; k++) begin
            drive_pulse(4'b1000);
            if (k == 3) check_val("irq_lag", 32'(irq), 0);
            drive_pulse(4'b0000);
        end
        check_val("irq_set", 32'(irq), 32'(m_irq_en & (|m_match)));
        axi_read(8'h04, "status_match");
        axi_write(8'h04, 32'h0008_0000);
        check_val("irq_clr", 32'(irq), 32'(m_irq_en & (|m_match)));
`endif

        // reset with a read response pending and a write presented
        frame_pulse = '0;
        araddr = 8'h80; arvalid = 1'b1;
        for (int n = 0; n < 16 && !arready; n++) @(negedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        rst = 1'b1;
        awaddr = 8'h00; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        check_val("rst_abort_rvalid", 32'(rvalid), 0);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_val("abort_bvalid", 32'(bvalid), 0);
            check_val("abort_rvalid", 32'(rvalid), 0);
        end
        read_all("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
